bsg_sort_iter: RTL and testbench



---
 rtl/bsg_sort_iter_if.sv | 31 +++
 rtl/bsg_sort_iter.sv | 146 ++++++++++++++
 tb/tb_bsg_sort_iter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bsg_sort_iter_if.sv
// bsg_sort_iter_if
//   Handshake bundle for bsg_sort_iter.
//   Input side : v_i / ready_o accept one packed key vector (data_i).
//   Output side: v_o / yumi_i hand off the sorted vector (data_o) and
//                the saturating swap count (swap_count_o).
//   Element k of a vector sits at [k*width_p +: width_p].
//   slave modport : the sorter.
//   master modport: the producer/consumer around it.
interface bsg_sort_iter_if #(
  parameter int unsigned width_p     = 16,
  parameter int unsigned els_p       = 4,
  parameter int unsigned cnt_width_p = 8
);
  logic                     v_i;
  logic [els_p*width_p-1:0] data_i;
  logic                     ready_o;
  logic                     v_o;
  logic [els_p*width_p-1:0] data_o;
  logic                     yumi_i;
  logic [cnt_width_p-1:0]   swap_count_o;

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, swap_count_o
  );

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, swap_count_o
  );
endinterface

// File: rtl/bsg_sort_iter.sv
// bsg_sort_iter
//   Iterative odd-even transposition sorter for els_p unsigned keys of
//   width_p bits. One vector is accepted on v_i & ready_o, one phase of
//   compare-and-swap is applied per clock, and the ascending result
//   (element 0 smallest) is held on data_o while v_o is high until yumi_i.
//   Ports:
//     clk_i    clock
//     reset_i  asynchronous active-high reset; discards any in-flight vector
//     io       bsg_sort_iter_if.slave (v_i, data_i, ready_o, v_o, data_o,
//              yumi_i, swap_count_o)
//   swap_count_o accumulates the swaps performed on the current vector and
//   saturates at 2^cnt_width_p-1.
//   Optional: define BSG_SORT_ITER_EARLY_EXIT_EN to finish as soon as two
//   consecutive phases perform no swap (data_o is unchanged by this).
module bsg_sort_iter #(
  parameter int unsigned width_p     = 16,
  parameter int unsigned els_p       = 4,
  parameter int unsigned cnt_width_p = 8
) (
  input logic             clk_i,
  input logic             reset_i,
  bsg_sort_iter_if.slave  io
);

  localparam int unsigned ph_w  = (els_p > 2) ? $clog2(els_p) : 1;
  localparam int unsigned sw_w  = $clog2(els_p / 2 + 1);
  localparam int unsigned sum_w = ((cnt_width_p > sw_w) ? cnt_width_p : sw_w) + 1;

  localparam logic [ph_w-1:0]  last_phase = ph_w'(els_p - 1);
  localparam logic [sum_w-1:0] cnt_max    = (sum_w'(1) << cnt_width_p) - sum_w'(1);

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_e;

  state_e                   state_r, state_n;
  logic [els_p*width_p-1:0] data_r, data_n;
  logic [ph_w-1:0]          phase_r;
  logic [cnt_width_p-1:0]   count_r, count_n;
  logic [sw_w-1:0]          phase_swaps;
  logic [sum_w-1:0]         count_sum;
  logic                     accept;
  logic                     last;
  logic                     exit_now;

  assign accept = (state_r == IDLE) & io.v_i;
  assign last   = (phase_r == last_phase);

  // One transposition phase. Even phases pair (0,1),(2,3)...; odd phases
  // pair (1,2),(3,4)... Pairs within a phase are disjoint, so every compare
  // reads the registered vector. Equal keys never swap (stable sort).
  always_comb begin
    data_n      = data_r;
    phase_swaps = '0;
    for (int unsigned k = 0; k + 1 < els_p; k++) begin
      if (k[0] == phase_r[0]) begin
        if (data_r[k*width_p +: width_p] > data_r[(k+1)*width_p +: width_p]) begin
          data_n[k*width_p +: width_p]     = data_r[(k+1)*width_p +: width_p];
          data_n[(k+1)*width_p +: width_p] = data_r[k*width_p +: width_p];
          phase_swaps                      = phase_swaps + sw_w'(1);
        end
      end
    end
  end

  // Saturating accumulate, computed one bit wider to detect overflow.
  always_comb begin
    count_sum = sum_w'(count_r) + sum_w'(phase_swaps);
    count_n   = (count_sum > cnt_max) ? '1 : cnt_width_p'(count_sum);
  end

`ifdef BSG_SORT_ITER_EARLY_EXIT_EN
  // Remembers whether the previously applied phase was swap-free.
  logic prev_zero_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prev_zero_r <= 1'b0;
    end else if (accept) begin
      prev_zero_r <= 1'b0;
    end else if (state_r == SORT) begin
      prev_zero_r <= (phase_swaps == '0);
    end
  end

  // Two consecutive swap-free phases (one even, one odd) mean every
  // adjacent pair is ordered, so the vector is already sorted.
  always_comb begin
    exit_now = last | ((phase_r != '0) & prev_zero_r & (phase_swaps == '0));
  end
`else
  always_comb begin
    exit_now = last;
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n    = state_r;
    io.ready_o = 1'b0;
    io.v_o     = 1'b0;
    unique case (state_r)
      IDLE: begin
        io.ready_o = 1'b1;
        if (io.v_i) state_n = SORT;
      end
      SORT: begin
        if (exit_now) state_n = DONE;
      end
      DONE: begin
        io.v_o = 1'b1;
        if (io.yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_r  <= '0;
      phase_r <= '0;
      count_r <= '0;
    end else if (accept) begin
      data_r  <= io.data_i;
      phase_r <= '0;
      count_r <= '0;
    end else if (state_r == SORT) begin
      data_r  <= data_n;
      phase_r <= phase_r + ph_w'(1);
      count_r <= count_n;
    end
  end

  assign io.data_o       = data_r;
  assign io.swap_count_o = count_r;

endmodule

// File: tb/tb_bsg_sort_iter.sv
module tb_bsg_sort_iter;
  localparam int W = 16;
  localparam int N = 4;
  localparam int C = 8;

`ifdef BSG_SORT_ITER_EARLY_EXIT_EN
  localparam int SORTED_LAT = 2;
  localparam int SAME_LAT   = 2;
`else
  localparam int SORTED_LAT = 4;
  localparam int SAME_LAT   = 4;
`endif
  localparam int FULL_LAT = 4;

  logic clk = 1'b0;
  logic reset_i;

  always #5 clk = ~clk;

  bsg_sort_iter_if #(.width_p(W), .els_p(N), .cnt_width_p(C)) bus();

  bsg_sort_iter #(.width_p(W), .els_p(N), .cnt_width_p(C)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (bus)
  );

  typedef struct packed {
    logic [N*W-1:0] d;
    logic [C-1:0]   c;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   presented = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] pack4(input logic [15:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation when a new output is presented, then
  // checks it stays stable until the consumer takes it.
  always @(negedge clk) begin
    if (reset_i === 1'b1) begin
      presented = 1'b0;
    end else if (bus.v_o === 1'b1) begin
      if (!presented) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h with no vector pending", bus.data_o);
        end else begin
          cur = exp_q.pop_front();
          check("data_o", bus.data_o, cur.d);
          check("swap_count_o", 64'(bus.swap_count_o), 64'(cur.c));
          presented = 1'b1;
        end
      end else begin
        check("hold_data_o", bus.data_o, cur.d);
        check("hold_swap_count_o", 64'(bus.swap_count_o), 64'(cur.c));
      end
      if (bus.yumi_i === 1'b1) presented = 1'b0;
    end
  end

  task automatic push(input logic [63:0] d, input logic [7:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Presents a vector and returns #1 after the acceptance edge.
  task automatic send(input logic [63:0] v);
    int n;
    n = 0;
    bus.v_i    = 1'b1;
    bus.data_i = v;
    while (!bus.ready_o && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_accept", 64'(bus.ready_o), 64'd1);
    @(posedge clk); #1;
    bus.v_i = 1'b0;
  endtask

  // Counts edges after acceptance until v_o; a timeout shows as a wrong count.
  task automatic wait_v(input string nm, input int exp_lat);
    int n;
    n = 0;
    while (!bus.v_o && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, 64'(n), 64'(exp_lat));
  endtask

  task automatic take();
    bus.yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
    check("v_o_after_yumi", 64'(bus.v_o), 64'd0);
    check("ready_after_yumi", 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i    = 1'b1;
    bus.v_i    = 1'b0;
    bus.data_i = '0;
    bus.yumi_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready_o), 64'd1);
    check("reset_v_o", 64'(bus.v_o), 64'd0);
    check("reset_count", 64'(bus.swap_count_o), 64'd0);
    check("reset_data", bus.data_o, 64'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 64'(bus.ready_o), 64'd1);

    // Reverse order
    push(pack4(16'd1, 16'd2, 16'd3, 16'd4), 8'd6);
    send(pack4(16'd4, 16'd3, 16'd2, 16'd1));
    check("sort_ready_low", 64'(bus.ready_o), 64'd0);
    wait_v("lat_reverse", FULL_LAT);
    take();

    // Already sorted
    push(pack4(16'd1, 16'd2, 16'd3, 16'd4), 8'd0);
    send(pack4(16'd1, 16'd2, 16'd3, 16'd4));
    wait_v("lat_sorted", SORTED_LAT);
    take();

    // Ties / stability
    push(pack4(16'd2, 16'd2, 16'd7, 16'd7), 8'd3);
    send(pack4(16'd7, 16'd2, 16'd7, 16'd2));
    wait_v("lat_ties", FULL_LAT);
    take();

    // Backpressure with v_i pulses in DONE
    push(pack4(16'd1, 16'd8, 16'd8, 16'd9), 8'd5);
    send(pack4(16'd9, 16'd8, 16'd8, 16'd1));
    wait_v("lat_backpressure", FULL_LAT);
    bus.data_i = pack4(16'd0, 16'd0, 16'd0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      bus.v_i = i[0];
      @(posedge clk); #1;
      check("bp_ready_low", 64'(bus.ready_o), 64'd0);
      check("bp_v_o_high", 64'(bus.v_o), 64'd1);
    end
    bus.v_i = 1'b0;
    take();

    // Reset mid-SORT: the vector must vanish
    send(pack4(16'd4, 16'd3, 16'd2, 16'd1));
    @(posedge clk); #1;
    reset_i = 1'b1;
    #1;
    check("midreset_v_o", 64'(bus.v_o), 64'd0);
    check("midreset_ready", 64'(bus.ready_o), 64'd1);
    check("midreset_count", 64'(bus.swap_count_o), 64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_orphan_output", 64'(bus.v_o), 64'd0);
    end

    // Back-to-back with v_i held high
    push(pack4(16'h0000, 16'h0001, 16'h8000, 16'hFFFF), 8'd4);
    push(pack4(16'd5, 16'd5, 16'd5, 16'd5), 8'd0);
    bus.v_i    = 1'b1;
    bus.data_i = pack4(16'hFFFF, 16'h0000, 16'h8000, 16'h0001);
    @(posedge clk); #1;
    bus.data_i = pack4(16'd5, 16'd5, 16'd5, 16'd5);
    wait_v("lat_b2b_first", FULL_LAT);
    bus.yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.yumi_i = 1'b0;
    check("b2b_idle_ready", 64'(bus.ready_o), 64'd1);
    check("b2b_idle_v_o", 64'(bus.v_o), 64'd0);
    @(posedge clk); #1;
    check("b2b_accepted", 64'(bus.ready_o), 64'd0);
    bus.v_i = 1'b0;
    wait_v("lat_b2b_second", SAME_LAT);
    take();

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
